// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the two-requester data-memory arbiter:
// FSM state encoding, requester count and an alignment helper.
package dmem_arb_pkg;

  localparam int NUM_RQ = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  function automatic logic is_aligned(input logic [1:0] addr_lsb);
    return (addr_lsb == 2'b00);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester, response and data-memory bundle for dmem_arbiter.
// slave is the arbiter's view; master is the requesters' and memory's view.
interface dmem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  import dmem_arb_pkg::*;

  logic [NUM_RQ-1:0]             rq_valid;
  logic [NUM_RQ-1:0]             rq_write;
  logic [NUM_RQ-1:0][ADDR_W-1:0] rq_addr;
  logic [NUM_RQ-1:0][DATA_W-1:0] rq_wdata;
  logic [NUM_RQ-1:0]             rq_ready;
  logic [NUM_RQ-1:0]             rsp_valid;
  logic [DATA_W-1:0]             rsp_rdata;
  logic                          rsp_err;
  logic                          MemRead;
  logic                          MemWrite;
  logic [ADDR_W-1:0]             mem_addr;
  logic [DATA_W-1:0]             mem_wdata;
  logic [DATA_W-1:0]             mem_rdata;

  modport slave (
    input  rq_valid, rq_write, rq_addr, rq_wdata, mem_rdata,
    output rq_ready, rsp_valid, rsp_rdata, rsp_err,
           MemRead, MemWrite, mem_addr, mem_wdata
  );

  modport master (
    output rq_valid, rq_write, rq_addr, rq_wdata, mem_rdata,
    input  rq_ready, rsp_valid, rsp_rdata, rsp_err,
           MemRead, MemWrite, mem_addr, mem_wdata
  );

endinterface

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way round-robin picker: a lone valid requester wins; when both are
// valid, the one that was not granted last time wins.
module rr_pick2 (
  input  logic [1:0] valid,
  input  logic       last,
  output logic [1:0] grant
);

  // one-hot grant selection
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter: IDLE grants and latches one request,
// ACCESS strobes memory for one cycle, RESP returns a one-cycle completion.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  dmem_arbiter_if.slave  bus
);

  state_t            state_r;
  logic              last_r;
  logic              idx_r;
  logic              wr_r;
  logic              mem_read_r;
  logic              mem_write_r;
  logic [ADDR_W-1:0] mem_addr_r;
  logic [DATA_W-1:0] mem_wdata_r;
  logic [1:0]        rsp_valid_r;
  logic [DATA_W-1:0] rsp_rdata_r;
  logic              rsp_err_r;

  logic [1:0]        pick_s;
  logic [1:0]        grant_s;
  logic              sel_s;

  rr_pick2 u_pick (
    .valid (bus.rq_valid),
    .last  (last_r),
    .grant (pick_s)
  );

  // grants are only offered from IDLE and are suppressed while reset is held
  always_comb begin
    grant_s = 2'b00;
    if (rst_n && (state_r == ST_IDLE)) begin
      grant_s = pick_s;
    end else begin
      grant_s = 2'b00;
    end
    sel_s = grant_s[1];
  end

  assign bus.rq_ready  = grant_s;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_rdata = rsp_rdata_r;
  assign bus.rsp_err   = rsp_err_r;
  assign bus.MemRead   = mem_read_r;
  assign bus.MemWrite  = mem_write_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;

  // FSM, request latch, memory strobes and response registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      last_r      <= 1'b1;
      idx_r       <= 1'b0;
      wr_r        <= 1'b0;
      mem_read_r  <= 1'b0;
      mem_write_r <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {DATA_W{1'b0}};
      rsp_valid_r <= 2'b00;
      rsp_rdata_r <= {DATA_W{1'b0}};
      rsp_err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          rsp_valid_r <= 2'b00;
          if (grant_s != 2'b00) begin
            last_r      <= sel_s;
            idx_r       <= sel_s;
            wr_r        <= bus.rq_write[sel_s];
            mem_addr_r  <= bus.rq_addr[sel_s];
            mem_wdata_r <= bus.rq_wdata[sel_s];
            if (is_aligned(bus.rq_addr[sel_s][1:0])) begin
              state_r     <= ST_ACCESS;
              mem_read_r  <= ~bus.rq_write[sel_s];
              mem_write_r <= bus.rq_write[sel_s];
            end else begin
              // misaligned: skip memory, report error right away
              state_r     <= ST_RESP;
              rsp_valid_r <= grant_s;
              rsp_rdata_r <= {DATA_W{1'b0}};
              rsp_err_r   <= 1'b1;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          mem_read_r  <= 1'b0;
          mem_write_r <= 1'b0;
          rsp_rdata_r <= wr_r ? {DATA_W{1'b0}} : bus.mem_rdata;
          rsp_err_r   <= 1'b0;
          rsp_valid_r <= idx_r ? 2'b10 : 2'b01;
          state_r     <= ST_RESP;
        end
        ST_RESP: begin
          rsp_valid_r <= 2'b00;
          rsp_rdata_r <= {DATA_W{1'b0}};
          rsp_err_r   <= 1'b0;
          state_r     <= ST_IDLE;
        end
        default: begin
          mem_read_r  <= 1'b0;
          mem_write_r <= 1'b0;
          rsp_valid_r <= 2'b00;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a small word memory
// attached to the memory side of the interface.
module tb_dmem_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [31:0] mem [16];
  logic [1:0]  order [4];

  dmem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_rdata = bus.MemRead ? mem[bus.mem_addr[5:2]] : 32'h0000_0000;

  always @(posedge clk) begin
    if (bus.MemWrite) mem[bus.mem_addr[5:2]] <= bus.mem_wdata;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("rw_exclusive", 64'(bus.MemRead & bus.MemWrite), 64'd0);
      chk("rsp_onehot", 64'(bus.rsp_valid == 2'b11), 64'd0);
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic run_txn(input int idx, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] exp_rdata);
    logic [1:0] oh;
    logic       mis;
    int         waited;
    oh  = (idx == 1) ? 2'b10 : 2'b01;
    mis = (addr[1:0] != 2'b00);
    @(negedge clk);
    bus.rq_valid       = 2'b00;
    bus.rq_valid[idx]  = 1'b1;
    bus.rq_write[idx]  = wr;
    bus.rq_addr[idx]   = addr;
    bus.rq_wdata[idx]  = wdata;
    #1;
    waited = 0;
    while (bus.rq_ready == 2'b00 && waited < 8) begin
      @(negedge clk);
      #1;
      waited++;
    end
    chk("grant", 64'(bus.rq_ready), 64'(oh));
    chk("grant_wait", 64'(waited), 64'd0);
    @(posedge clk);
    #1 bus.rq_valid = 2'b00;
    @(negedge clk);
    if (mis) begin
      chk("mis_rd", 64'(bus.MemRead), 64'd0);
      chk("mis_wr", 64'(bus.MemWrite), 64'd0);
      chk("mis_rsp", 64'(bus.rsp_valid), 64'(oh));
      chk("mis_err", 64'(bus.rsp_err), 64'd1);
      chk("mis_rdata", 64'(bus.rsp_rdata), 64'd0);
    end else begin
      chk("acc_wr", 64'(bus.MemWrite), 64'(wr));
      chk("acc_rd", 64'(bus.MemRead), 64'(!wr));
      chk("acc_addr", 64'(bus.mem_addr), 64'(addr));
      if (wr) chk("acc_wdata", 64'(bus.mem_wdata), 64'(wdata));
      chk("acc_no_rsp", 64'(bus.rsp_valid), 64'd0);
      @(negedge clk);
      chk("rsp_valid", 64'(bus.rsp_valid), 64'(oh));
      chk("rsp_err", 64'(bus.rsp_err), 64'd0);
      chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(exp_rdata));
      chk("rsp_strobes", 64'({bus.MemRead, bus.MemWrite}), 64'd0);
    end
    @(negedge clk);
    chk("rsp_done", 64'(bus.rsp_valid), 64'd0);
  endtask

  initial begin
    int ng;
    int nr;
    checks = 0;
    errors = 0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0000 + 32'(i);
    order[0] = 2'b01; order[1] = 2'b10; order[2] = 2'b01; order[3] = 2'b10;
    bus.rq_valid = 2'b11;
    bus.rq_write = 2'b00;
    bus.rq_addr  = '{32'h0, 32'h0};
    bus.rq_wdata = '{32'h0, 32'h0};
    rst_n = 1'b0;

    // reset state, with both requesters pushing
    #12;
    chk("rst_ready", 64'(bus.rq_ready), 64'd0);
    chk("rst_rsp", 64'(bus.rsp_valid), 64'd0);
    chk("rst_strobes", 64'({bus.MemRead, bus.MemWrite}), 64'd0);
    chk("rst_addr", 64'(bus.mem_addr), 64'd0);
    chk("rst_rdata_err", 64'({bus.rsp_rdata, bus.rsp_err}), 64'd0);
    bus.rq_valid = 2'b00;
    @(posedge clk);
    #1 rst_n = 1'b1;

    run_txn(0, 1'b1, 32'h0000_0000, 32'hdead_beef, 32'h0);
    run_txn(1, 1'b1, 32'h0000_0004, 32'h1234_5678, 32'h0);
    run_txn(0, 1'b0, 32'h0000_0004, 32'h0, 32'h1234_5678);
    run_txn(1, 1'b0, 32'h0000_0000, 32'h0, 32'hdead_beef);
    run_txn(1, 1'b0, 32'h0000_0006, 32'h0, 32'h0);

    // round-robin with both requesters continuously loading from 0x0
    do_reset();
    ng = 0;
    nr = 0;
    @(negedge clk);
    bus.rq_valid = 2'b11;
    bus.rq_write = 2'b00;
    bus.rq_addr  = '{32'h0, 32'h0};
    for (int c = 0; c < 40 && nr < 4; c++) begin
      #1;
      if (bus.rq_ready != 2'b00) begin
        if (ng < 4) chk("rr_grant", 64'(bus.rq_ready), 64'(order[ng]));
        else chk("rr_extra_grant", 64'(bus.rq_ready), 64'd0);
        ng++;
      end
      if (bus.rsp_valid != 2'b00) begin
        if (nr < 4) chk("rr_rsp", 64'(bus.rsp_valid), 64'(order[nr]));
        chk("rr_rdata", 64'(bus.rsp_rdata), 64'hdead_beef);
        nr++;
      end
      @(posedge clk);
      #1;
      if (ng >= 4) bus.rq_valid = 2'b00;
      @(negedge clk);
    end
    chk("rr_rsp_count", 64'(nr), 64'd4);
    chk("rr_grant_count", 64'(ng), 64'd4);
    bus.rq_valid = 2'b00;
    @(negedge clk);
    @(negedge clk);

    // reset pulsed in the middle of a store's ACCESS cycle
    @(negedge clk);
    bus.rq_valid    = 2'b01;
    bus.rq_write[0] = 1'b1;
    bus.rq_addr[0]  = 32'h0000_0008;
    bus.rq_wdata[0] = 32'hcafe_f00d;
    #1 chk("abort_grant", 64'(bus.rq_ready), 64'd1);
    @(posedge clk);
    #1 bus.rq_valid = 2'b00;
    chk("abort_pre_wr", 64'(bus.MemWrite), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_wr", 64'(bus.MemWrite), 64'd0);
    chk("abort_rd", 64'(bus.MemRead), 64'd0);
    chk("abort_addr", 64'(bus.mem_addr), 64'd0);
    chk("abort_wdata", 64'(bus.mem_wdata), 64'd0);
    chk("abort_rsp", 64'(bus.rsp_valid), 64'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk("abort_rsp_hold", 64'(bus.rsp_valid), 64'd0);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    run_txn(0, 1'b0, 32'h0000_0008, 32'h0, 32'h1000_0002);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, width of requester and memory addresses.
REQ-002 Parameter DATA_W, default 32, width of write and read data.
REQ-003 One clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 rq_valid  input  2  per-requester access request; bit 0 is the CPU load/store port, bit 1 is the debug/loader port.
REQ-007 rq_write  input  2  per-requester access type: 1 for store, 0 for load.
REQ-008 rq_addr  input  2xADDR_W  per-requester byte address.
REQ-009 rq_wdata  input  2xDATA_W  per-requester store data.
REQ-010 rq_ready  output  2  one-hot grant pulse; the request is accepted in the cycle that rq_valid and rq_ready are both high.
REQ-011 rsp_valid  output  2  one-hot completion pulse.
REQ-012 rsp_rdata  output  DATA_W  load data; valid only with rsp_valid.
REQ-013 rsp_err  output  1  misaligned-access flag; valid only with rsp_valid.
REQ-014 MemRead  output  1  data memory read strobe.
REQ-015 MemWrite  output  1  data memory write strobe.
REQ-016 mem_addr  output  ADDR_W  data memory address.
REQ-017 mem_wdata  output  DATA_W  data memory write data.
REQ-018 mem_rdata  input  DATA_W  data memory read data; combinational from mem_addr when MemRead is high.

Function
REQ-019 The FSM SHALL have three states.
- IDLE: waiting for a request.
- ACCESS: memory access in progress.
- RESP: response being returned.
REQ-020 In IDLE with any rq_valid bit set, the block SHALL assert rq_ready for exactly one selected requester, combinationally in the same cycle.
- It SHALL latch that requester's write, addr, wdata and index.
REQ-021 Selection when both requesters are valid SHALL be round-robin.
- The requester not granted most recently wins.
- After reset, requester 0 has priority.
REQ-022 An accepted aligned request (addr[1:0]==0) SHALL move the FSM IDLE->ACCESS.
- In ACCESS, the block drives mem_addr and mem_wdata from the latch.
- It asserts exactly one of MemWrite (store) or MemRead (load) for exactly one cycle.
REQ-023 At the end of ACCESS, a load SHALL capture mem_rdata into the response register, and the FSM SHALL move ACCESS->RESP.
REQ-024 A misaligned request SHALL move IDLE->RESP directly, with no memory strobe and rsp_err=1.
REQ-025 In RESP, the block SHALL pulse rsp_valid for the latched requester for one cycle, then move RESP->IDLE.
- For loads, rsp_rdata holds the captured data.
- For stores and errors, rsp_rdata=0.
- For aligned requests, rsp_err=0.
REQ-026 Aligned request latency SHALL be acceptance cycle + 2 (rsp_valid two cycles after the rq_ready cycle); throughput SHALL be one access per 3 cycles.
REQ-027 The block SHALL NOT assert rq_ready in ACCESS or RESP.
- Requests arriving in those states wait.
- A new grant is possible in the first IDLE cycle after RESP.
REQ-028 The block SHALL NOT assert MemRead and MemWrite simultaneously, and SHALL drive both low outside ACCESS.
REQ-029 mem_addr and mem_wdata SHALL hold their latched values outside ACCESS; their values there are don't-care to memory.
REQ-030 A requester dropping rq_valid without a grant SHALL NOT be granted, and its priority standing SHALL be unchanged.

Reset
REQ-031 Asserting rst_n low SHALL immediately force the following, including mid-ACCESS, which aborts the access with no response issued:
- FSM=IDLE
- rq_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0
- MemRead=0, MemWrite=0, mem_addr=0, mem_wdata=0
- round-robin pointer = requester 0 priority
REQ-032 The first grant SHALL be possible in the first rising edge cycle after rst_n deasserts.

Structure
REQ-033 Shared package dmem_arb_pkg SHALL hold the state encoding (IDLE, ACCESS, RESP) and the requester-count constant (2).
REQ-034 Round-robin selection SHALL be a sub-module rr_pick2 taking valid[1:0] and last-grant, returning a one-hot grant; the FSM and latches remain in dmem_arbiter.

Verification
REQ-035 Store from rq0: addr 0x0, wdata 0xdeadbeef.
- Required: MemWrite high for one cycle with mem_addr 0x0.
- Required: rsp_valid=01 two cycles after the grant, rsp_err=0.
REQ-036 Store from rq1: addr 0x4, wdata 0x12345678. Then load from rq0 at 0x4 and load from rq1 at 0x0.
- Required: rsp_rdata 0x12345678 for rq0.
- Required: rsp_rdata 0xdeadbeef for rq1.
REQ-037 Both valid in the same cycle, repeated 4 times with loads at 0x0.
- Required grant order after reset: 01, 10, 01, 10.
- Required: no overlapping responses.
REQ-038 Misaligned load at 0x6 from rq1.
- Required: no MemRead or MemWrite.
- Required: rsp_valid=10 one cycle after the grant, rsp_err=1, rsp_rdata=0.
REQ-039 rst_n pulsed low during ACCESS of a store at 0x8.
- Required: MemWrite drops immediately and no rsp_valid is issued.
- Required: a subsequent load at 0x8 is granted in the first cycle after reset and returns the memory's prior contents.
